// File: rtl/countdown_timer_core.sv
// BCD countdown engine: minutes setting, run/pause, second prescaler and an alarm
// that can silence itself after ALARM_SECS seconds.
module countdown_timer_core #(
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned MAX_MINS     = 99,
    parameter int unsigned DEFAULT_MINS = 1,
    parameter int unsigned ALARM_SECS   = 30
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       up,
    input  logic       dn,
    input  logic       cancel,
    input  logic       start_stop,
    output logic [3:0] secs,
    output logic [3:0] ten_secs,
    output logic [3:0] mins,
    output logic [3:0] ten_mins,
    output logic       alarm_on,
    output logic [1:0] state,
    output logic       tick
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [3:0] MAX_T = 4'(MAX_MINS / 10);
    localparam logic [3:0] MAX_U = 4'(MAX_MINS % 10);
    localparam logic [3:0] DEF_T = 4'(DEFAULT_MINS / 10);
    localparam logic [3:0] DEF_U = 4'(DEFAULT_MINS % 10);
    localparam logic [3:0] BLANK = 4'd10;

    typedef enum logic [1:0] {
        S_SETTING = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2,
        S_BEEPING = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    secs_q, secs_d, tsecs_q, tsecs_d, mins_q, mins_d, tmins_q, tmins_d;
    logic [3:0]    tmdisp_q, tmdisp_d;
    logic [7:0]    stored_q, stored_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic          alarm_q, alarm_d, tick_q, tick_d;

    logic presc_top, at_max, at_one, time_one, alarm_done, restore;

    assign presc_top  = (presc_q == PRESC_TOP);
    assign at_max     = ({tmins_q, mins_q} == {MAX_T, MAX_U});
    assign at_one     = ({tmins_q, mins_q} == 8'h01);
    assign time_one   = ({tmins_q, mins_q, tsecs_q, secs_q} == 16'h0001);
    assign alarm_done = (ALARM_SECS != 0) && presc_top && ((32'(acnt_q) + 32'd1) == ALARM_SECS);
    // Any transition back into SETTING is a restore; SETTING never restores itself.
    assign restore    = (state_d == S_SETTING) && (state_q != S_SETTING);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_SETTING;
            secs_q   <= '0;
            tsecs_q  <= '0;
            mins_q   <= DEF_U;
            tmins_q  <= DEF_T;
            tmdisp_q <= (DEF_T == 4'd0) ? BLANK : DEF_T;
            stored_q <= {DEF_T, DEF_U};
            presc_q  <= '0;
            acnt_q   <= '0;
            alarm_q  <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            secs_q   <= secs_d;
            tsecs_q  <= tsecs_d;
            mins_q   <= mins_d;
            tmins_q  <= tmins_d;
            tmdisp_q <= tmdisp_d;
            stored_q <= stored_d;
            presc_q  <= presc_d;
            acnt_q   <= acnt_d;
            alarm_q  <= alarm_d;
            tick_q   <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SETTING: if (start_stop) state_d = S_RUNNING;
            S_RUNNING: begin
                if (cancel)                     state_d = S_SETTING;
                else if (start_stop)            state_d = S_PAUSED;
                else if (presc_top && time_one) state_d = S_BEEPING;
            end
            S_PAUSED: begin
                if (cancel)          state_d = S_SETTING;
                else if (start_stop) state_d = S_RUNNING;
            end
            S_BEEPING: if (cancel || start_stop || alarm_done) state_d = S_SETTING;
            default: state_d = S_SETTING;
        endcase
    end

    always_comb begin
        secs_d   = secs_q;
        tsecs_d  = tsecs_q;
        mins_d   = mins_q;
        tmins_d  = tmins_q;
        stored_d = stored_q;
        presc_d  = presc_q;
        acnt_d   = acnt_q;
        alarm_d  = alarm_q;
        tick_d   = 1'b0;
        if (restore) begin
            secs_d  = '0;
            tsecs_d = '0;
            mins_d  = stored_q[3:0];
            tmins_d = stored_q[7:4];
            presc_d = '0;
            acnt_d  = '0;
            alarm_d = 1'b0;
        end else begin
            case (state_q)
                S_SETTING: begin
                    if (start_stop) begin
                        stored_d = {tmins_q, mins_q};
                        presc_d  = '0;
                    end else if (up && !dn) begin
                        if (at_max) begin
                            tmins_d = '0;
                            mins_d  = 4'd1;
                        end else if (mins_q == 4'd9) begin
                            mins_d  = '0;
                            tmins_d = tmins_q + 4'd1;
                        end else begin
                            mins_d = mins_q + 4'd1;
                        end
                    end else if (dn && !up) begin
                        if (at_one) begin
                            tmins_d = MAX_T;
                            mins_d  = MAX_U;
                        end else if (mins_q == 4'd0) begin
                            mins_d  = 4'd9;
                            tmins_d = tmins_q - 4'd1;
                        end else begin
                            mins_d = mins_q - 4'd1;
                        end
                    end
                end
                S_RUNNING: begin
                    if (!start_stop) begin
                        presc_d = presc_top ? '0 : presc_q + PW'(1);
                        if (presc_top) begin
                            tick_d = 1'b1;
                            if (secs_q != 4'd0) begin
                                secs_d = secs_q - 4'd1;
                            end else begin
                                secs_d = 4'd9;
                                if (tsecs_q != 4'd0) begin
                                    tsecs_d = tsecs_q - 4'd1;
                                end else begin
                                    tsecs_d = 4'd5;
                                    if (mins_q != 4'd0) begin
                                        mins_d = mins_q - 4'd1;
                                    end else begin
                                        mins_d  = 4'd9;
                                        tmins_d = tmins_q - 4'd1;
                                    end
                                end
                            end
                            if (time_one) begin
                                alarm_d = 1'b1;
                                acnt_d  = '0;
                            end
                        end
                    end
                end
                S_BEEPING: begin
                    presc_d = presc_top ? '0 : presc_q + PW'(1);
                    if (presc_top && (ALARM_SECS != 0)) acnt_d = acnt_q + AW'(1);
                end
                default: ;
            endcase
        end
        tmdisp_d = (tmins_d == 4'd0) ? BLANK : tmins_d;
    end

    assign secs     = secs_q;
    assign ten_secs = tsecs_q;
    assign mins     = mins_q;
    assign ten_mins = tmdisp_q;
    assign alarm_on = alarm_q;
    assign state    = state_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Two parameterisations of the timer run against a seconds-count reference model,
// with directed scenarios followed by random button traffic.
module tb_countdown_timer_core;

    localparam int TD = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] up, dn, cancel, ss;
    logic [3:0] secs_w[2], tsecs_w[2], mins_w[2], tmins_w[2];
    logic [1:0] state_w[2];
    logic       alarm_w[2], tick_w[2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int maxm[2] = '{12, 99};
    int asec[2] = '{3, 0};
    int defm[2] = '{1, 3};

    always #5 CLK = ~CLK;

    countdown_timer_core #(.TICK_DIV(TD), .MAX_MINS(12), .DEFAULT_MINS(1), .ALARM_SECS(3)) dut_a (
        .CLK(CLK), .RST(RST), .up(up[0]), .dn(dn[0]), .cancel(cancel[0]), .start_stop(ss[0]),
        .secs(secs_w[0]), .ten_secs(tsecs_w[0]), .mins(mins_w[0]), .ten_mins(tmins_w[0]),
        .alarm_on(alarm_w[0]), .state(state_w[0]), .tick(tick_w[0])
    );

    countdown_timer_core #(.TICK_DIV(TD), .MAX_MINS(99), .DEFAULT_MINS(3), .ALARM_SECS(0)) dut_b (
        .CLK(CLK), .RST(RST), .up(up[1]), .dn(dn[1]), .cancel(cancel[1]), .start_stop(ss[1]),
        .secs(secs_w[1]), .ten_secs(tsecs_w[1]), .mins(mins_w[1]), .ten_mins(tmins_w[1]),
        .alarm_on(alarm_w[1]), .state(state_w[1]), .tick(tick_w[1])
    );

    // Reference: time is a plain count of seconds remaining; minutes setting is remain/60.
    typedef struct {
        int st;
        int remain;
        int stored;
        int presc;
        int acnt;
        bit alarm;
        bit tick;
    } mdl_t;

    mdl_t m[2];

    function automatic mdl_t mdl_reset(input int k);
        mdl_t r;
        r.st = 0; r.remain = defm[k] * 60; r.stored = defm[k];
        r.presc = 0; r.acnt = 0; r.alarm = 0; r.tick = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_restore(input mdl_t r);
        r.st = 0; r.remain = r.stored * 60; r.presc = 0; r.alarm = 0; r.acnt = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t r, input int k, input bit u, input bit d,
                                      input bit c, input bit s);
        int v;
        r.tick = 0;
        case (r.st)
            0: begin
                if (s) begin
                    r.stored = r.remain / 60; r.presc = 0; r.st = 1;
                end else if (u != d) begin
                    v = r.remain / 60 - 1 + (u ? 1 : maxm[k] - 1);
                    r.remain = (v % maxm[k] + 1) * 60;
                end
            end
            1: begin
                if (c) r = mdl_restore(r);
                else if (s) r.st = 2;
                else if (r.presc == TD - 1) begin
                    r.presc = 0; r.tick = 1; r.remain--;
                    if (r.remain == 0) begin r.st = 3; r.alarm = 1; r.acnt = 0; end
                end else r.presc++;
            end
            2: begin
                if (c) r = mdl_restore(r);
                else if (s) r.st = 1;
            end
            default: begin
                if (c || s) r = mdl_restore(r);
                else if (r.presc == TD - 1) begin
                    r.presc = 0;
                    if (asec[k] > 0) begin
                        r.acnt++;
                        if (r.acnt == asec[k]) r = mdl_restore(r);
                    end
                end else r.presc++;
            end
        endcase
        return r;
    endfunction

    function automatic logic [19:0] expv(input mdl_t r);
        int mm, sc, tm;
        mm = r.remain / 60; sc = r.remain % 60; tm = mm / 10;
        return {2'(r.st), 4'(tm == 0 ? 10 : tm), 4'(mm % 10), 4'(sc / 10), 4'(sc % 10), r.alarm, r.tick};
    endfunction

    function automatic logic [19:0] dutv(input int k);
        return {state_w[k], tmins_w[k], mins_w[k], tsecs_w[k], secs_w[k], alarm_w[k], tick_w[k]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m[0] <= mdl_reset(0);
            m[1] <= mdl_reset(1);
        end else begin
            m[0] <= mdl_step(m[0], 0, up[0], dn[0], cancel[0], ss[0]);
            m[1] <= mdl_step(m[1], 1, up[1], dn[1], cancel[1], ss[1]);
        end
    end

    always @(negedge CLK) begin
        cyc++;
        for (int k = 0; k < 2; k++)
            check_eq($sformatf("cyc%0d_dut%0d", cyc, k), 32'(dutv(k)), 32'(expv(m[k])));
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic press(input int k, input bit u, input bit d, input bit c, input bit s);
        up[k] = u; dn[k] = d; cancel[k] = c; ss[k] = s;
        @(posedge CLK); #1;
        up[k] = 1'b0; dn[k] = 1'b0; cancel[k] = 1'b0; ss[k] = 1'b0;
    endtask

    task automatic wait_beep(input int k, input string tag);
        int n;
        n = 0;
        while (m[k].st != 3 && n < 600) begin idle(1); n++; end
        check_eq(tag, 32'(state_w[k]), 32'd3);
    endtask

    function automatic logic [7:0] disp_mins(input int k);
        return {tmins_w[k], mins_w[k]};
    endfunction

    initial begin
        int n;
        up = '0; dn = '0; cancel = '0; ss = '0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1; RST = 1'b0;
        idle(1);
        check_eq("rst_a", 32'(dutv(0)), 32'({2'd0, 4'd10, 4'd1, 8'h00, 2'b00}));
        check_eq("rst_b", 32'(dutv(1)), 32'({2'd0, 4'd10, 4'd3, 8'h00, 2'b00}));

        // minutes wrap on MAX_MINS=12
        press(0, 0, 1, 0, 0); check_eq("dn_wrap", 32'(disp_mins(0)), 32'h12);
        press(0, 1, 0, 0, 0); check_eq("up_wrap", 32'(disp_mins(0)), 32'hA1);
        repeat (9) press(0, 1, 0, 0, 0);
        check_eq("up_x9", 32'(disp_mins(0)), 32'h10);
        press(0, 1, 1, 0, 0); check_eq("up_dn", 32'(disp_mins(0)), 32'h10);
        press(0, 0, 0, 1, 0); check_eq("cancel_set", 32'(disp_mins(0)), 32'h10);
        repeat (3) press(0, 1, 0, 0, 0);
        check_eq("back_to_1", 32'(disp_mins(0)), 32'hA1);

        // first tick after TICK_DIV cycles
        press(0, 0, 0, 0, 1); check_eq("run", 32'(state_w[0]), 32'd1);
        idle(3); check_eq("no_early_tick", 32'(tick_w[0]), 32'd0);
        idle(1);
        check_eq("first_tick", 32'({tick_w[0], disp_mins(0), tsecs_w[0], secs_w[0]}), 32'({1'b1, 8'hA0, 8'h59}));

        // pause keeps prescaler position
        idle(4); idle(2);
        press(0, 0, 0, 0, 1); check_eq("paused", 32'(state_w[0]), 32'd2);
        idle(40);
        check_eq("pause_hold", 32'({tsecs_w[0], secs_w[0]}), 32'h58);
        press(0, 0, 0, 0, 1);
        idle(1); check_eq("resume_wait", 32'(tick_w[0]), 32'd0);
        idle(1);
        check_eq("resume_tick", 32'({tick_w[0], tsecs_w[0], secs_w[0]}), 32'({1'b1, 8'h57}));

        press(0, 0, 0, 1, 1);
        check_eq("cancel_ss", 32'(dutv(0)), 32'({2'd0, 4'd10, 4'd1, 8'h00, 2'b00}));

        // full countdown and auto-silence
        press(0, 0, 0, 0, 1);
        wait_beep(0, "beep_a");
        check_eq("beep_zero", 32'(dutv(0)), 32'({2'd3, 4'd10, 4'd0, 8'h00, 2'b11}));
        idle(11); check_eq("still_beep", 32'({state_w[0], alarm_w[0]}), 32'({2'd3, 1'b1}));
        idle(1);
        check_eq("auto_silence", 32'(dutv(0)), 32'({2'd0, 4'd10, 4'd1, 8'h00, 2'b00}));

        // start_stop beats up
        press(0, 1, 0, 0, 0);
        press(0, 1, 0, 0, 1);
        check_eq("ss_up", 32'({state_w[0], disp_mins(0)}), 32'({2'd1, 8'hA2}));
        idle(5);
        press(0, 0, 0, 1, 0);
        check_eq("stored_pre", 32'(dutv(0)), 32'({2'd0, 4'd10, 4'd2, 8'h00, 2'b00}));

        // cancel on the auto-silence tick
        press(0, 0, 1, 0, 0);
        press(0, 0, 0, 0, 1);
        wait_beep(0, "beep_a2");
        idle(11);
        press(0, 0, 0, 1, 0);
        check_eq("cancel_on_silence", 32'(dutv(0)), 32'({2'd0, 4'd10, 4'd1, 8'h00, 2'b00}));

        // ALARM_SECS=0 never silences
        press(1, 0, 1, 0, 0); press(1, 0, 1, 0, 0);
        press(1, 0, 0, 0, 1);
        wait_beep(1, "beep_b");
        idle(1000);
        check_eq("no_silence", 32'({state_w[1], alarm_w[1]}), 32'({2'd3, 1'b1}));
        press(1, 0, 0, 1, 0);
        check_eq("cancel_b", 32'({state_w[1], alarm_w[1]}), 32'({2'd0, 1'b0}));

        // asynchronous reset mid-run
        repeat (4) press(0, 1, 0, 0, 0);
        press(0, 0, 0, 0, 1);
        n = 0;
        while (m[0].remain != 37 && n < 2000) begin idle(1); n++; end
        check_eq("at_0037", 32'({disp_mins(0), tsecs_w[0], secs_w[0]}), 32'h A037);
        #3 RST = 1'b1;
        #1;
        check_eq("async_rst", 32'(dutv(0)), 32'({2'd0, 4'd10, 4'd1, 8'h00, 2'b00}));
        @(posedge CLK); #1; RST = 1'b0;
        idle(1);
        press(0, 0, 0, 0, 1);
        idle(4);
        check_eq("run_default", 32'(dutv(0)), 32'({2'd1, 4'd10, 4'd0, 8'h59, 2'b01}));

        // random button traffic
        repeat (3000) begin
            for (int k = 0; k < 2; k++) begin
                up[k]     = ($urandom_range(0, 11) == 0);
                dn[k]     = ($urandom_range(0, 11) == 0);
                cancel[k] = ($urandom_range(0, 199) == 0);
                ss[k]     = ($urandom_range(0, 39) == 0);
            end
            @(posedge CLK); #1;
        end
        up = '0; dn = '0; cancel = '0; ss = '0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
